// File: rtl/btn_pkg.sv
// btn_pkg: shared sizing helpers for the button event arbiter.
// Provides the button-index width derivation and the layout of one queued
// event entry {id, rpt}, with the repeat flag in the least significant bit.
package btn_pkg;

  // Bit position of the auto-repeat flag inside a queued entry.
  localparam int RPT_BIT = 0;

  // Width of a button index; a single-bit index is kept even for tiny counts.
  function automatic int idw_of(input int n_btn);
    return (n_btn > 1) ? $clog2(n_btn) : 1;
  endfunction

  // Width of one queued event entry: index plus repeat flag.
  function automatic int entry_w(input int n_btn);
    return idw_of(n_btn) + 1;
  endfunction

endpackage

// File: rtl/btn_filter.sv
// btn_filter: conditioning for one push-button (sync, debounce, press detect,
// pending slot). Ports: clk, rst (sync, active-low), tick (shared sample strobe),
// btn_raw (pad), grant (arbiter took the slot), held, pend, pend_rpt, drop.
// Optional feature macro AUTOREPEAT_EN adds a per-button repeat counter.
module btn_filter #(
  parameter int DB_LEN        = 4
`ifdef AUTOREPEAT_EN
  , parameter int REPEAT_START  = 64
  , parameter int REPEAT_PERIOD = 16
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  input  logic grant,
  output logic held,
  output logic pend,
  output logic pend_rpt,
  output logic drop
);

  logic [1:0]        sync;
  logic [DB_LEN-1:0] sr;
  logic              held_prev;
  logic              press;
  logic              slot_free;
  logic              pend_next;

  assign press     = held & ~held_prev;
  // A slot granted this cycle is free again for a press arriving now.
  assign slot_free = ~pend | grant;

`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_START + 1);
  logic [RW-1:0] rcnt;
  logic          rpt_fire;
  logic          rpt_next;

  assign rpt_fire = held && tick && (rcnt == RW'(REPEAT_START - 1));

  // After the first repeat the counter is rewound so that the next fire
  // lands REPEAT_PERIOD ticks later, which keeps it bounded for long holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rcnt <= '0;
    end else if (!held) begin
      rcnt <= '0;
    end else if (tick) begin
      rcnt <= rpt_fire ? RW'(REPEAT_START - REPEAT_PERIOD) : rcnt + 1'b1;
    end
  end

  always_comb begin
    pend_next = pend & ~grant;
    rpt_next  = pend_rpt;
    drop      = 1'b0;
    if (press) begin
      pend_next = 1'b1;
      rpt_next  = 1'b0;
      drop      = ~slot_free;
    end else if (rpt_fire && slot_free) begin
      // A repeat colliding with an occupied slot is discarded without ovf.
      pend_next = 1'b1;
      rpt_next  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) pend_rpt <= 1'b0;
    else      pend_rpt <= rpt_next;
  end
`else
  always_comb begin
    pend_next = (pend & ~grant) | press;
    drop      = press & ~slot_free;
  end

  assign pend_rpt = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync      <= '0;
      sr        <= '0;
      held      <= 1'b0;
      held_prev <= 1'b0;
      pend      <= 1'b0;
    end else begin
      sync <= {sync[0], btn_raw};
      if (tick) sr <= {sr[DB_LEN-2:0], sync[1]};
      // Hysteresis: only a unanimous history moves the debounced level.
      if (&sr)       held <= 1'b1;
      else if (~|sr) held <= 1'b0;
      held_prev <= held;
      pend      <= pend_next;
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: serialises debounced button presses into a queued
// ready/valid event stream. Ports: clk, rst (sync, active-low), btn_raw, held,
// evt_valid/evt_id/evt_rpt/evt_ready (event queue head), ovf (drop pulse).
// Optional feature macro AUTOREPEAT_EN enables auto-repeat events (evt_rpt=1).
module button_event_arbiter
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int TICK_DIV      = 18,
  parameter int DB_LEN        = 4,
  parameter int FIFO_DEPTH    = 4,
  parameter int REPEAT_START  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_BTN-1:0]           btn_raw,
  output logic [N_BTN-1:0]           held,
  output logic                       evt_valid,
  output logic [idw_of(N_BTN)-1:0]   evt_id,
  output logic                       evt_rpt,
  input  logic                       evt_ready,
  output logic                       ovf
);

  localparam int IDW = idw_of(N_BTN);
  localparam int EW  = entry_w(N_BTN);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  if (N_BTN < 2 || N_BTN > 8) begin : g_bad_nbtn
    $error("N_BTN must be in 2..8");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two >= 2");
  end
  if (REPEAT_PERIOD < 1 || REPEAT_START < REPEAT_PERIOD) begin : g_bad_rpt
    $error("need 1 <= REPEAT_PERIOD <= REPEAT_START");
  end

  logic [TICK_DIV-1:0] tcnt;
  logic                tick;
  logic [N_BTN-1:0]    pend, pend_rpt, drop, grant;
  logic [IDW-1:0]      rr_ptr, gnt_id;
  logic [IDW:0]        sum;
  logic                gnt_vld, push, pop, push_ok;

  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic [EW-1:0]       head;

  assign tick = &tcnt;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_filter #(
      .DB_LEN        (DB_LEN)
`ifdef AUTOREPEAT_EN
      , .REPEAT_START  (REPEAT_START)
      , .REPEAT_PERIOD (REPEAT_PERIOD)
`endif
    ) u_filter (
      .clk      (clk),
      .rst      (rst),
      .tick     (tick),
      .btn_raw  (btn_raw[g]),
      .grant    (grant[g]),
      .held     (held[g]),
      .pend     (pend[g]),
      .pend_rpt (pend_rpt[g]),
      .drop     (drop[g])
    );
  end

  // Round-robin search: first pending index at or after rr_ptr, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    for (int i = 0; i < N_BTN; i++) begin
      sum = {1'b0, rr_ptr} + (IDW+1)'(i);
      if (sum >= (IDW+1)'(N_BTN)) sum = sum - (IDW+1)'(N_BTN);
      if (!gnt_vld && pend[sum[IDW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = sum[IDW-1:0];
      end
    end
  end

  assign pop     = evt_valid && evt_ready;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign push_ok = (count < CW'(FIFO_DEPTH)) || pop;
  assign push    = gnt_vld && push_ok;

  always_comb begin
    grant = '0;
    if (push) grant[gnt_id] = 1'b1;
  end

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign evt_id    = head[EW-1:1];
  assign evt_rpt   = head[RPT_BIT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt   <= '0;
      rr_ptr <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
      ovf  <= |drop;
      if (push) begin
        mem[wr_ptr] <= {gnt_id, pend_rpt[gnt_id]};
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (gnt_id == IDW'(N_BTN - 1)) ? '0 : gnt_id + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed bench for button_event_arbiter.
// Small tick divider so debouncing completes in a handful of cycles.
// With AUTOREPEAT_EN defined an extra auto-repeat scenario is exercised.
module tb_button_event_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] held;
  logic       evt_valid;
  logic [1:0] evt_id;
  logic       evt_rpt;
  logic       evt_ready = 1'b0;
  logic       ovf;

  int n_cmp   = 0;
  int n_bad   = 0;
  int ovf_cnt = 0;

  button_event_arbiter #(
    .N_BTN        (4),
    .TICK_DIV     (2),
    .DB_LEN       (4),
    .FIFO_DEPTH   (4),
    .REPEAT_START (8),
    .REPEAT_PERIOD(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_raw  (btn_raw),
    .held     (held),
    .evt_valid(evt_valid),
    .evt_id   (evt_id),
    .evt_rpt  (evt_rpt),
    .evt_ready(evt_ready),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (rst && ovf) ovf_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Waits (bounded) for a head entry, records it and pops it with a one-cycle ready.
  task automatic pop_one(output logic [1:0] id, output logic rpt, output logic ok);
    int b;
    b = 0;
    while (!evt_valid && b < 60) begin
      step(1);
      b++;
    end
    ok  = evt_valid;
    id  = evt_id;
    rpt = evt_rpt;
    if (ok) begin
      evt_ready = 1'b1;
      step(1);
      evt_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [1:0] id;
    logic       rpt, ok;
    int         nev, b;
    logic [1:0] last_id;
    logic [1:0] exp_ord [4];

    // Reset values
    rst = 1'b0;
    step(3);
    check("rst_held", held, 0);
    check("rst_valid", evt_valid, 0);
    check("rst_id", evt_id, 0);
    check("rst_rpt", evt_rpt, 0);
    check("rst_ovf", ovf, 0);

    // Single press of button 2: sample ticks at edges 4,8,12,16, held at 17
    rst = 1'b1;
    btn_raw = 4'b0100;
    step(16);
    check("held2_early", held[2], 0);
    step(1);
    check("held2_rise", held[2], 1);
    step(1);
    check("valid_t1", evt_valid, 0);
    step(1);
    check("valid_t2", evt_valid, 1);
    check("single_id", evt_id, 2);
    check("single_rpt", evt_rpt, 0);
    evt_ready = 1'b1;
    step(1);
    evt_ready = 1'b0;
    check("pop_empty", evt_valid, 0);

    // Release produces no event
    btn_raw = 4'b0000;
    step(30);
    check("release_held", held, 0);
    check("release_noevt", evt_valid, 0);

    // Bounce on button 0: toggles once per tick for 10 ticks, then steady
    ovf_cnt   = 0;
    nev       = 0;
    last_id   = 2'd3;
    evt_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      btn_raw[0] = ~k[0];
      for (int c = 0; c < 4; c++) begin
        step(1);
        if (evt_valid) begin nev++; last_id = evt_id; end
      end
    end
    btn_raw[0] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      step(1);
      if (evt_valid) begin nev++; last_id = evt_id; end
    end
    btn_raw[0] = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step(1);
      if (evt_valid) begin nev++; last_id = evt_id; end
    end
    evt_ready = 1'b0;
    check("bounce_count", nev, 1);
    check("bounce_id", last_id, 0);
    check("bounce_ovf", ovf_cnt, 0);

    // Press button 1 alone so the round-robin pointer lands on 2
    btn_raw = 4'b0010;
    pop_one(id, rpt, ok);
    check("b1_ok", ok, 1);
    check("b1_id", id, 1);
    btn_raw = 4'b0000;
    step(30);

    // Simultaneous press of all four with ready low: queue fills 2,3,0,1
    ovf_cnt = 0;
    btn_raw = 4'b1111;
    step(30);
    check("sim_valid", evt_valid, 1);
    check("sim_head", evt_id, 2);
    // Button 1 twice more: first waits pending, second merges and drops
    btn_raw = 4'b1101;
    step(30);
    check("b1_rel1", held, 4'b1101);
    btn_raw = 4'b1111;
    step(30);
    check("b1_press2", held, 4'b1111);
    btn_raw = 4'b1101;
    step(30);
    btn_raw = 4'b1111;
    step(30);
    check("full_ovf", ovf_cnt, 1);
    check("full_stable_id", evt_id, 2);
    check("full_count", dut.count, 4);

    // One pop while full with button 1 pending: refilled in the same cycle
    pop_one(id, rpt, ok);
    check("pwf_id", id, 2);
    check("pwf_count", dut.count, 4);
    exp_ord[0] = 2'd3; exp_ord[1] = 2'd0; exp_ord[2] = 2'd1; exp_ord[3] = 2'd1;
    for (int k = 0; k < 4; k++) begin
      pop_one(id, rpt, ok);
      check("drain_ok", ok, 1);
      check("drain_id", id, exp_ord[k]);
    end
    step(2);
    check("drain_empty", evt_valid, 0);
    btn_raw = 4'b0000;
    step(30);
    check("drain_noextra", evt_valid, 0);

    // Mid-operation reset flushes a queued event
    btn_raw = 4'b0001;
    b = 0;
    while (!evt_valid && b < 60) begin step(1); b++; end
    check("mid_pre_valid", evt_valid, 1);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    btn_raw = 4'b0000;
    check("mid_valid", evt_valid, 0);
    check("mid_held", held, 0);
    check("mid_id", evt_id, 0);
    step(40);
    check("mid_quiet", evt_valid, 0);

`ifdef AUTOREPEAT_EN
    // Hold button 3: fresh press, then repeats at held-ticks 8, 12, 16
    evt_ready = 1'b1;
    btn_raw   = 4'b1000;
    b = 0;
    while (!held[3] && b < 60) begin step(1); b++; end
    check("ar_held", held[3], 1);
    nev = 0;
    for (int c = 0; c < 74; c++) begin
      step(1);
      if (evt_valid) begin
        check("ar_id", evt_id, 3);
        check("ar_rpt", evt_rpt, (nev == 0) ? 0 : 1);
        nev++;
      end
    end
    check("ar_count", nev, 4);
    btn_raw   = 4'b0000;
    evt_ready = 1'b0;
    step(30);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
